// File: rtl/md_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MD_SIGNED_EN to enable two's-complement operation via signed_op.
module md_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIGN_FIX = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StDone} state_e;
  state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q, neg_hi_q, neg_lo_q, dz_q;
  logic               done_q, div0_q, hilo_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic sgn;
`ifdef MD_SIGNED_EN
  assign sgn = signed_op && (SIGN_FIX != 0);
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn = 1'b0;
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = sgn && a[WIDTH-1];
  assign b_neg = sgn && b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, quotient}.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opb_q};

  logic [2*WIDTH-1:0] acc_fix;
  always_comb begin
    acc_fix = acc_q;
    if (op_q) begin
      if (neg_hi_q) acc_fix[2*WIDTH-1:WIDTH] = ~acc_q[2*WIDTH-1:WIDTH] + 1'b1;
      if (neg_lo_q) acc_fix[WIDTH-1:0] = ~acc_q[WIDTH-1:0] + 1'b1;
    end else if (neg_lo_q) begin
      acc_fix = ~acc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op && (b == '0)) state_d = StDone;
          else                 state_d = op ? StDiv : StMult;
        end
      end
      StMult, StDiv: begin
        if (cnt_q == '0) state_d = (SIGN_FIX != 0) ? StFix : StDone;
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hilo_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      hilo_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= op;
            dz_q     <= op && (b == '0);
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            opb_q    <= op ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (op ? a_mag : b_mag)};
            cnt_q    <= CW'(WIDTH - 1);
          end
        end
        StMult: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q - 1'b1;
        end
        StDiv: begin
          if (div_diff[WIDTH]) acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else                 acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          cnt_q <= cnt_q - 1'b1;
        end
        StFix: acc_q <= acc_fix;
        StDone: begin
          done_q <= 1'b1;
          div0_q <= dz_q;
          hilo_q <= !dz_q;
          if (!dz_q) begin
            hi_q <= acc_q[2*WIDTH-1:WIDTH];
            lo_q <= acc_q[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign div0       = div0_q;
  assign hilo_write = hilo_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random operations
// against an arithmetic reference model.
module tb_md_unit;
  localparam int W = 32;
`ifdef MD_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset, start, op, signed_op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div0, hilo_write;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  md_unit #(.WIDTH(W), .SIGN_FIX(1)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hilo_write(hilo_write),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero, '%' follows dividend.
  function automatic logic [63:0] ref_md(input logic o, input logic sg,
                                         input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    if (!o) begin
      res = 64'(sx * sy);
    end else begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // rp >= 0 re-pulses start with junk operands that many cycles into the operation.
  task automatic run_op(input string tag, input logic o, input logic sg,
                        input logic [W-1:0] x, input logic [W-1:0] y, input int rp);
    logic [63:0] exp;
    logic dz;
    int n, lat;
    dz  = o && (y == '0);
    exp = dz ? {mhi, mlo} : ref_md(o, sg && SignedEn, x, y);
    lat = dz ? 1 : W + 2;
    start = 1'b1; op = o; signed_op = sg; a = x; b = y;
    tick;
    start = 1'b0; op = 1'($urandom); signed_op = 1'($urandom); a = $urandom; b = $urandom;
    chk({tag, ":busy_on"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      start = (n == rp);
      if (n == rp) begin
        a = $urandom;
        b = $urandom;
      end
      tick;
      n++;
    end
    start = 1'b0;
    chk({tag, ":latency"}, 64'(n), 64'(lat));
    chk({tag, ":div0"}, {63'd0, div0}, {63'd0, dz});
    chk({tag, ":hilo_write"}, {63'd0, hilo_write}, {63'd0, !dz});
    chk({tag, ":busy_off"}, {63'd0, busy}, 64'd0);
    chk({tag, ":result"}, {hi, lo}, exp);
    if (!dz) {mhi, mlo} = exp;
    tick;
    chk({tag, ":done_drop"}, {62'd0, done, hilo_write}, 64'd0);
    chk({tag, ":hold"}, {hi, lo}, {mhi, mlo});
  endtask

  initial begin
    logic [W-1:0] x, y;
    int base;
    reset = 1'b1; start = 1'b0; op = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    #2;
    chk("reset_out", {busy, done, div0, hilo_write, hi, lo[W-1:4]}, 64'd0);
    tick;
    tick;
    reset = 1'b0;
    tick;

    run_op("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, -1);
    chk("umul_max_lit", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    run_op("smul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, -1);
`ifdef MD_SIGNED_EN
    chk("smul_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif
    run_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
`ifdef MD_SIGNED_EN
    chk("sdiv_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
    run_op("sdiv_min", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
`ifdef MD_SIGNED_EN
    chk("sdiv_min_lit", {hi, lo}, 64'h0000_0000_8000_0000);
`endif

    run_op("preload", 1'b1, 1'b0, 32'd65, 32'd10, -1);
    chk("preload_lit", {hi, lo}, 64'h0000_0005_0000_0006);
    run_op("div0", 1'b1, 1'b0, 32'd9, 32'd0, -1);
    chk("div0_keep", {hi, lo}, 64'h0000_0005_0000_0006);

    base = done_cnt;
    run_op("repulse", 1'b0, 1'b0, 32'd123457, 32'd98765, 10);
    repeat (40) tick;
    chk("repulse_one_done", 64'(done_cnt - base), 64'd1);

    // Abort a divide mid-flight.
    start = 1'b1; op = 1'b1; signed_op = 1'b0; a = 32'd100000; b = 32'd7;
    tick;
    start = 1'b0;
    repeat (14) tick;
    base = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort_out", {busy, done, div0, hilo_write, hi, lo[W-1:4]}, 64'd0);
    mhi = '0;
    mlo = '0;
    tick;
    reset = 1'b0;
    repeat (40) tick;
    chk("abort_no_done", 64'(done_cnt - base), 64'd0);
    run_op("after_abort", 1'b1, 1'b0, 32'd100000, 32'd7, -1);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = $urandom_range(1, 15);
        default: ;
      endcase
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x, y, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 32, operand width (even, >= 4).
REQ-002 The parameter list SHALL also be: SIGN_FIX, default 1, 1 inserts the FIX state for sign correction, 0 omits it and forces an unsigned-only datapath.
REQ-003 Port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  request pulse, sampled only in IDLE.
REQ-006 Port op  in  1  operation select: 0 multiply, 1 divide.
REQ-007 Port signed_op  in  1  selects a signed operation (see Configuration).
REQ-008 Port a, b  in  WIDTH each  operand A (multiplicand / dividend) and operand B (multiplier / divisor).
REQ-009 Port busy  out  1  high while an operation is in flight.
REQ-010 Port done  out  1  one-cycle completion pulse.
REQ-011 Port div0  out  1  one-cycle pulse, coincident with done, on a divide by zero.
REQ-012 Port hilo_write  out  1  one-cycle pulse, coincident with done, whenever hi/lo were updated.
REQ-013 Port hi, lo  out  WIDTH each  result registers.

Function
REQ-014 The FSM SHALL have the states IDLE, MULT, DIV, FIX, DONE.
REQ-015 In IDLE with start=1 at edge T, the block SHALL latch a, b, op, signed_op and move to MULT or DIV; busy SHALL be 1 from T+1 until done.
REQ-016 MULT SHALL do radix-2 shift-add, one bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-017 DIV SHALL do restoring division, one quotient bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL last one cycle and apply sign correction (identity for unsigned operations), then go to DONE.
REQ-019 With SIGN_FIX=0, the block SHALL go from MULT/DIV directly to DONE, with latency one cycle shorter.
REQ-020 Latency: done, hilo_write and busy=0 SHALL occur in the cycle after edge T+WIDTH+2; hi/lo SHALL be valid in that same cycle.
REQ-021 DONE SHALL last one cycle and then return to IDLE; a start is accepted again in the next IDLE cycle.
REQ-022 Multiply result: {hi,lo} SHALL be the 2*WIDTH-bit product.
REQ-023 Divide result: lo SHALL be the quotient and hi the remainder.
REQ-024 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-025 Signed MIN / -1 SHALL give lo=MIN, hi=0, with no error flag.
REQ-026 If op=1 and b=0 at acceptance, the block SHALL skip DIV and FIX and go straight to DONE; done and div0 SHALL pulse in the cycle after T+1, hilo_write SHALL stay 0, and hi/lo SHALL keep their previous values.
REQ-027 A start while busy=1 SHALL be ignored, and operand changes during busy SHALL have no effect.
REQ-028 hi/lo SHALL change only in DONE with hilo_write=1 and SHALL hold otherwise.

Reset
REQ-029 Reset SHALL asynchronously force: state IDLE; busy, done, div0, hilo_write = 0; hi, lo, and all internal operand, accumulator and counter registers = 0.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-032 The macro MD_SIGNED_EN SHALL control signed-operation support.
REQ-033 When MD_SIGNED_EN is defined, signed_op=1 SHALL select two's-complement operation by magnitude conversion at acceptance plus correction in FIX.
REQ-034 When MD_SIGNED_EN is undefined, signed_op SHALL be ignored, all operations SHALL be unsigned, and the port SHALL remain present.

Verification
REQ-035 Scenario, WIDTH=32 unsigned multiply: a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE, done 34 cycles after the start edge.
REQ-036 Scenario, signed multiply with MD_SIGNED_EN: a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 Scenario, signed divide: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-038 Scenario, divide by zero: hi/lo preloaded to 5/6, then a=9, b=0 -> done and div0 pulse 2 cycles after start, hilo_write=0, hi/lo remain 5/6.
REQ-039 Scenario, start re-pulsed at cycle 10 of a multiply with different operands -> the original result is unaffected and exactly one done occurs.
REQ-040 Scenario, reset asserted at cycle 15 of a divide -> outputs zero immediately, no done pulse; the next start completes correctly.
